// File: rtl/sync_fifo_arbiter.sv
// Round-robin arbiter feeding one shared sync_fifo, with credit-based overrun protection and a flush sequencer.
// Define SYNC_FIFO_ARBITER_PERF_EN to build the perf_grants/perf_stalls counters.
module sync_fifo_arbiter #(
  parameter int NUM_REQUESTERS = 4,
  parameter int WIDTH          = 64,
  parameter int FIFO_SIZE      = 8
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_REQUESTERS-1:0]                request,
  input  logic [NUM_REQUESTERS-1:0][WIDTH-1:0]     request_data,
  output logic [NUM_REQUESTERS-1:0]                grant,
  input  logic                                     flush_req,
  output logic                                     flush_busy,
  output logic                                     fifo_enqueue_en,
  output logic [WIDTH-1:0]                         fifo_value,
  output logic                                     fifo_flush_en,
  input  logic                                     fifo_dequeue_en,
  output logic [$clog2(FIFO_SIZE):0]               credits,
  output logic [31:0]                              perf_grants,
  output logic [31:0]                              perf_stalls
);

  localparam int PW = $clog2(NUM_REQUESTERS);
  localparam int CW = $clog2(FIFO_SIZE) + 1;
  localparam logic [CW-1:0] FULL_CREDITS = CW'(FIFO_SIZE);
  localparam logic [PW-1:0] LAST_IDX     = PW'(NUM_REQUESTERS - 1);
  localparam logic [PW:0]   REQ_COUNT    = (PW+1)'(NUM_REQUESTERS);

  typedef enum logic [1:0] {RUN, DRAIN, FLUSH} state_t;

  state_t        state;
  logic [PW-1:0] pointer;
  logic [PW-1:0] grant_idx;
  logic [PW-1:0] scan_idx;
  logic [PW:0]   scan_sum;
  logic          grant_valid;
  logic          can_grant;
  logic [CW-1:0] credits_next;

  assign can_grant = (state == RUN) && (credits != '0) && !flush_req;

  // Scan request bits starting at the priority pointer, wrapping at NUM_REQUESTERS.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_sum    = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      scan_sum = {1'b0, pointer} + (PW+1)'(k);
      if (scan_sum >= REQ_COUNT)
        scan_sum = scan_sum - REQ_COUNT;
      scan_idx = scan_sum[PW-1:0];
      if (can_grant && !grant_valid && request[scan_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx;
      end
    end
    if (grant_valid)
      grant[grant_idx] = 1'b1;
  end

  always_comb begin
    credits_next = credits;
    if (state == FLUSH)
      credits_next = FULL_CREDITS;
    else if (grant_valid && !fifo_dequeue_en)
      credits_next = credits - 1'b1;
    else if (!grant_valid && fifo_dequeue_en && credits != FULL_CREDITS)
      credits_next = credits + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= RUN;
      pointer         <= '0;
      credits         <= FULL_CREDITS;
      fifo_enqueue_en <= 1'b0;
      fifo_value      <= '0;
      fifo_flush_en   <= 1'b0;
      flush_busy      <= 1'b0;
    end else begin
      credits         <= credits_next;
      fifo_enqueue_en <= grant_valid;
      if (grant_valid) begin
        fifo_value <= request_data[grant_idx];
        pointer    <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
      end
      case (state)
        RUN: begin
          if (flush_req) begin
            state      <= DRAIN;
            flush_busy <= 1'b1;
          end
        end
        DRAIN: begin
          state         <= FLUSH;
          fifo_flush_en <= 1'b1;
        end
        FLUSH: begin
          state         <= RUN;
          fifo_flush_en <= 1'b0;
          flush_busy    <= 1'b0;
          pointer       <= '0;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  // A dequeue with nothing outstanding, or a grant with no free slot, means the credit view has diverged from the FIFO.
  always_ff @(posedge clk) begin
    if (reset && state != FLUSH) begin
      assert (!(fifo_dequeue_en && !grant_valid && credits == FULL_CREDITS));
      assert (!(grant_valid && !fifo_dequeue_en && credits == '0));
    end
  end

`ifdef SYNC_FIFO_ARBITER_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_grants <= '0;
      perf_stalls <= '0;
    end else begin
      if (grant_valid)
        perf_grants <= perf_grants + 32'd1;
      if (|request && !grant_valid)
        perf_stalls <= perf_stalls + 32'd1;
    end
  end
`else
  assign perf_grants = '0;
  assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_sync_fifo_arbiter.sv
// Directed bench for sync_fifo_arbiter: a cycle model predicts grants/credits/flush outputs, a queue scoreboards enqueued data.
module tb_sync_fifo_arbiter;

  localparam int N  = 4;
  localparam int W  = 64;
  localparam int FS = 8;
  localparam int CW = $clog2(FS) + 1;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [N-1:0]          request;
  logic [N-1:0][W-1:0]   request_data;
  logic [N-1:0]          grant;
  logic                  flush_req;
  logic                  flush_busy;
  logic                  fifo_enqueue_en;
  logic [W-1:0]          fifo_value;
  logic                  fifo_flush_en;
  logic                  fifo_dequeue_en;
  logic [CW-1:0]         credits;
  logic [31:0]           perf_grants;
  logic [31:0]           perf_stalls;

  sync_fifo_arbiter #(.NUM_REQUESTERS(N), .WIDTH(W), .FIFO_SIZE(FS)) dut (
    .clk(clk),
    .reset(reset),
    .request(request),
    .request_data(request_data),
    .grant(grant),
    .flush_req(flush_req),
    .flush_busy(flush_busy),
    .fifo_enqueue_en(fifo_enqueue_en),
    .fifo_value(fifo_value),
    .fifo_flush_en(fifo_flush_en),
    .fifo_dequeue_en(fifo_dequeue_en),
    .credits(credits),
    .perf_grants(perf_grants),
    .perf_stalls(perf_stalls)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int step_no = 0;
  int seq = 0;
  logic [W-1:0] exp_q[$];

  // Model: 0=RUN 1=DRAIN 2=FLUSH
  int m_state;
  int m_ptr;
  int m_credits;
  int m_enq;
  int unsigned m_pg;
  int unsigned m_ps;

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s (step %0d): observed=%0h expected=%0h", tag, step_no, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_state   = 0;
    m_ptr     = 0;
    m_credits = FS;
    m_enq     = 0;
    m_pg      = 0;
    m_ps      = 0;
    exp_q.delete();
  endtask

  function automatic int modelGrant(input logic [N-1:0] req, input logic flush);
    if (m_state != 0 || m_credits == 0 || flush)
      return -1;
    for (int k = 0; k < N; k++)
      if (req[(m_ptr + k) % N])
        return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic newData(input int idx);
    seq++;
    request_data[idx] = {8'(idx), 24'(seq), 32'($urandom)};
  endtask

  // One clock cycle: drive inputs, sample mid-cycle against the model, advance model and clock.
  task automatic applyStimulus(input logic [N-1:0] req, input logic deq, input logic flush,
                               input logic rst_n = 1'b1);
    int g;
    logic [N-1:0] eg;
    request         = req;
    fifo_dequeue_en = deq;
    flush_req       = flush;
    reset           = rst_n;
    #4;
    step_no++;
    g  = modelGrant(req, flush);
    eg = '0;
    if (g >= 0)
      eg[g] = 1'b1;
    checkOutput("grant", W'(grant), W'(eg));
    checkOutput("credits", W'(credits), W'(m_credits));
    checkOutput("flush_busy", W'(flush_busy), W'(m_state != 0));
    checkOutput("fifo_flush_en", W'(fifo_flush_en), W'(m_state == 2));
    checkOutput("fifo_enqueue_en", W'(fifo_enqueue_en), W'(m_enq));
    if (fifo_enqueue_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("[TB] FAIL scoreboard_empty (step %0d): observed=enqueue expected=none", step_no);
      end else begin
        checkOutput("fifo_value", fifo_value, exp_q.pop_front());
      end
    end
`ifdef SYNC_FIFO_ARBITER_PERF_EN
    checkOutput("perf_grants", W'(perf_grants), W'(m_pg));
    checkOutput("perf_stalls", W'(perf_stalls), W'(m_ps));
`else
    checkOutput("perf_grants", W'(perf_grants), '0);
    checkOutput("perf_stalls", W'(perf_stalls), '0);
`endif
    if (!rst_n) begin
      modelReset();
    end else begin
      if (g >= 0) begin
        exp_q.push_back(request_data[g]);
        m_pg++;
        m_ptr = (g + 1) % N;
      end else if (|req) begin
        m_ps++;
      end
      m_enq = (g >= 0) ? 1 : 0;
      case (m_state)
        0: begin
          m_credits = m_credits + int'(deq) - ((g >= 0) ? 1 : 0);
          if (flush) m_state = 1;
        end
        1: begin
          m_credits = m_credits + int'(deq);
          m_state = 2;
        end
        default: begin
          m_credits = FS;
          m_ptr = 0;
          m_state = 0;
        end
      endcase
    end
    @(posedge clk);
    #1;
    if (g >= 0 && rst_n)
      newData(g);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset           = 1'b0;
    request         = '0;
    flush_req       = 1'b0;
    fifo_dequeue_en = 1'b0;
    for (int i = 0; i < N; i++)
      newData(i);
    repeat (2) @(posedge clk);
    #1;
    modelReset();
    reset = 1'b1;

    $display("[TB] reset state");
    checkOutput("rst_grant", W'(grant), '0);
    checkOutput("rst_credits", W'(credits), W'(FS));
    checkOutput("rst_fifo_value", fifo_value, '0);
    checkOutput("rst_enqueue_en", W'(fifo_enqueue_en), '0);
    checkOutput("rst_flush_en", W'(fifo_flush_en), '0);
    checkOutput("rst_flush_busy", W'(flush_busy), '0);

    $display("[TB] all requesting until credits run out");
    repeat (8) applyStimulus(4'b1111, 1'b0, 1'b0);
    checkOutput("t1_credits_zero", W'(credits), '0);
    repeat (5) applyStimulus(4'b1111, 1'b0, 1'b0);
`ifdef SYNC_FIFO_ARBITER_PERF_EN
    checkOutput("t1_perf_grants", W'(perf_grants), W'(8));
    checkOutput("t1_perf_stalls", W'(perf_stalls), W'(5));
`else
    checkOutput("t1_perf_grants", W'(perf_grants), '0);
    checkOutput("t1_perf_stalls", W'(perf_stalls), '0);
`endif

    $display("[TB] single dequeue at zero credits");
    applyStimulus(4'b0100, 1'b1, 1'b0);
    checkOutput("t2_credits_one", W'(credits), W'(1));
    applyStimulus(4'b0100, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("t2_credits_back", W'(credits), '0);

    $display("[TB] simultaneous grant and dequeue");
    repeat (3) applyStimulus(4'b0000, 1'b1, 1'b0);
    applyStimulus(4'b0001, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("t3_credits_hold", W'(credits), W'(3));

    $display("[TB] flush during traffic");
    applyStimulus(4'b0011, 1'b0, 1'b0);
    applyStimulus(4'b0011, 1'b0, 1'b1);
    applyStimulus(4'b0011, 1'b1, 1'b1);
    applyStimulus(4'b0011, 1'b1, 1'b0);
    checkOutput("t4_credits_restored", W'(credits), W'(FS));
    applyStimulus(4'b0011, 1'b0, 1'b0);
    applyStimulus(4'b0011, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0);

    $display("[TB] reset inside flush drain");
    applyStimulus(4'b0011, 1'b0, 1'b1);
    applyStimulus(4'b0011, 1'b0, 1'b0, 1'b0);
    checkOutput("t5_fifo_value", fifo_value, '0);
    checkOutput("t5_credits", W'(credits), W'(FS));
    checkOutput("t5_flush_busy", W'(flush_busy), '0);
    applyStimulus(4'b1000, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0);

    $display("[TB] mixed traffic");
    for (int c = 0; c < 40; c++) begin
      applyStimulus(N'($urandom), (m_credits < FS) ? 1'($urandom) : 1'b0, 1'b0);
    end
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("scoreboard_drained", W'(exp_q.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
